mdu_seq: RTL
============

// Module: mdu_seq
// PURPOSE
//   Iterative multiply/divide sequencer for MULT/MULTU/DIV/DIVU, plus the HI/LO register pair.
//   Sits beside the EX-stage ALU. ID/EX issues an op; the block runs one bit per cycle,
//   commits HI/LO and requests pipeline stalls while HI/LO results are pending.
// PARAMETERS
//   DATA_W   32  operand width; HI/LO width; iteration count = DATA_W
//   CNT_W    5   counter width, = clog2(DATA_W)
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       reset, asynchronous, active-low
//   start        in   1       issue op; sampled only in IDLE
//   op           in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val       in   DATA_W  multiplicand / dividend
//   rt_val       in   DATA_W  multiplier / divisor
//   flush        in   1       abort in-flight op (branch/exception squash)
//   hilo_access  in   1       EX holds MFHI/MFLO/MTHI/MTLO
//   mthi, mtlo   in   1 each  write wdata to HI / LO
//   wdata        in   DATA_W  MTHI/MTLO data
//   hi, lo       out  DATA_W  architectural HI/LO
//   busy         out  1       state != IDLE
//   done         out  1       one-cycle pulse: new HI/LO valid this cycle
//   stall_req    out  1       busy & (hilo_access | start)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE; hi=lo=0; busy=done=0; counter=0.
//     - Operates at any time, including mid-op; the in-flight op is lost.
//   States: IDLE, RUN, FIX.
//   IDLE:
//     - start=1 & !flush: latch op, |rs|, |rt| (abs only for signed ops), sign flags.
//       Go to RUN with cnt=0.
//     - DIV/DIVU with rt_val=0: skip RUN; stay IDLE; HI/LO unchanged; done=1 next cycle.
//   RUN:
//     - One shift-add (mult) or restoring shift-subtract (div) step per cycle, cnt++.
//     - cnt==DATA_W-1 -> FIX. So RUN lasts exactly DATA_W cycles.
//   FIX:
//     - Apply signs, write hi/lo, go to IDLE.
//     - done=1 in the following cycle; new hi/lo visible the same cycle as done.
//   Latency: start sampled at edge E0 -> done high in the cycle after edge E0+DATA_W+1 (34 cycles).
//   Sign rules:
//     - MULT: 64-bit product negated if signs differ; {hi,lo}=product.
//     - DIV: lo=quotient, negated if signs differ; hi=remainder, with the sign of the dividend.
//     - 0x80000000 / -1: lo=0x80000000, hi=0 (no trap).
//     - Unsigned ops: no sign handling; all arithmetic modulo 2^DATA_W per half.
//   flush:
//     - Synchronous; any state -> IDLE next edge; hi/lo unchanged; no done.
//     - flush & start in the same cycle: flush wins, op not started.
//   mthi/mtlo:
//     - Honoured only in IDLE; hi/lo take wdata next edge.
//     - Ignored while busy (the caller is stalled by stall_req).
//     - mthi & mtlo together both write.
//   start while busy: ignored; stall_req holds ID/EX until IDLE.
//   stall_req is combinational from busy; deasserts in the cycle done is high.
//   done never coincides with busy=1.
// TESTING
//   1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after start.
//   2. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged, done 1 cycle after start.
//   4. hilo_access=1 while busy -> stall_req=1 until done cycle; MTLO 0x1234 in IDLE -> lo=0x1234 next cycle.
//   5. flush at cnt=10 -> IDLE next cycle, no done, hi/lo keep previous values; start+flush same cycle -> no op.
//   6. rst_n low mid-RUN -> hi=lo=0, busy=0 immediately; a fresh MULTU 6*7 then gives lo=42.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer (one bit per cycle) owning the HI/LO pair.
// Rev 1.0
`default_nettype none

module mdu_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  input  logic              hilo_access,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              stall_req
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]          state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   divisor;
  logic                is_div, neg_q, neg_r;

  logic              op_div, op_signed, rs_neg, rt_neg, div_zero, accept;
  logic [DATA_W-1:0] rs_abs, rt_abs;

  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign rs_neg    = op_signed & rs_val[DATA_W-1];
  assign rt_neg    = op_signed & rt_val[DATA_W-1];
  assign rs_abs    = rs_neg ? -rs_val : rs_val;
  assign rt_abs    = rt_neg ? -rt_val : rt_val;
  assign div_zero  = op_div & (rt_val == '0);
  assign accept    = (state == S_IDLE) & start & ~flush;

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic                div_ok;
  logic [2*DATA_W-1:0] mul_next, div_next, prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, divisor} : {(DATA_W+1){1'b0}});
  assign mul_next  = {mul_sum, acc[DATA_W-1:1]};
  assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, divisor};
  assign div_ok    = ~div_diff[DATA_W];
  assign div_next  = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]), acc[DATA_W-2:0], div_ok};
  assign prod_fix  = neg_q ? -acc : acc;
  assign quo_fix   = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem_fix   = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && !div_zero) next_state = S_RUN;
        S_RUN:   if (cnt == CNT_LAST) next_state = S_FIX;
        S_FIX:   next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_IDLE);
    stall_req = busy & (hilo_access | start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      divisor <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt     <= '0;
        acc     <= {{DATA_W{1'b0}}, rs_abs};
        divisor <= rt_abs;
        is_div  <= op_div;
        neg_q   <= rs_neg ^ rt_neg;
        neg_r   <= rs_neg;
        // divide by zero never enters RUN: HI/LO stay as they are
        if (div_zero) done <= 1'b1;
      end else if (!flush && state == S_RUN) begin
        acc <= is_div ? div_next : mul_next;
        cnt <= cnt + CNT_W'(1);
      end else if (!flush && state == S_FIX) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*DATA_W-1:DATA_W];
          lo <= prod_fix[DATA_W-1:0];
        end
        done <= 1'b1;
      end
      if (state == S_IDLE) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

endmodule

`default_nettype wire
